mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters; requester 0 is the weight/bias loader.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles in WAIT before forced completion.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ: one-cycle request pulse per requester.
REQ-006 SHALL have port req_write, input, NUM_REQ: write flag per requester, sampled with req_valid.
REQ-007 SHALL have port req_addr, input, NUM_REQ*32: flattened byte addresses; requester i uses bits [32i+31:32i].
REQ-008 SHALL have port req_wdata, input, NUM_REQ*8: flattened write bytes.
REQ-009 SHALL have port resp_valid, output, NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port resp_data, output, 8: read byte, valid only while any resp_valid bit is high.
REQ-011 SHALL have ports mem_req_valid (output, 1), mem_req_write (output, 1), mem_req_addr (output, 32), mem_req_wdata (output, 8): the shared DDR request.
REQ-012 SHALL have ports mem_resp_valid (input, 1) and mem_resp_data (input, 8): the shared DDR response; every request, read or write, returns exactly one response.
REQ-013 SHALL have port err, output, 3: sticky flags {timeout, spurious_resp, overrun}.

Function
REQ-014 SHALL capture each req_valid[i] pulse into per-requester pending, addr, write and wdata registers; pending is visible the next cycle.
REQ-015 SHALL run FSM states IDLE and WAIT only.
REQ-016 IDLE: if any pending bit is set, SHALL select grant by round-robin starting at rr_ptr, assert mem_req_valid with the latched fields for exactly one cycle (registered), and enter WAIT.
REQ-017 Minimum latency: a req_valid pulse in cycle t SHALL produce mem_req_valid in cycle t+2 when the arbiter is idle.
REQ-018 WAIT: on mem_resp_valid in cycle r, SHALL pulse resp_valid[grant] and present resp_data in cycle r+1, clear pending[grant], set rr_ptr to grant+1 mod NUM_REQ, and return to IDLE.
REQ-019 Back-to-back: the next grant's mem_req_valid SHALL appear no earlier than cycle r+2.
REQ-020 A req_valid[i] pulse while pending[i] is set and not completing that cycle SHALL be dropped and SHALL set err[0].
REQ-021 A req_valid[grant] pulse in the same cycle as that requester's mem_resp_valid SHALL be accepted as a new pending request.
REQ-022 mem_resp_valid in IDLE SHALL be ignored and SHALL set err[1].
REQ-023 A WAIT counter SHALL reset on entry; at TIMEOUT_CYCLES cycles without a response the block SHALL pulse resp_valid[grant] with resp_data=0, set err[2], and return to IDLE.
REQ-024 err bits SHALL clear only on reset.
REQ-025 mem_req_addr, mem_req_write and mem_req_wdata SHALL hold their last values when mem_req_valid is low.

Reset
REQ-026 While rst_n is low, all outputs, pending bits, rr_ptr and the counter SHALL be 0, and state SHALL be IDLE.
REQ-027 Reset mid-WAIT SHALL abandon the outstanding request; a late mem_resp_valid after reset SHALL be treated as spurious.

Structure
REQ-028 The shared package/header mem_if_pkg SHALL hold the FSM encodings, ADDR_W=32, DATA_W=8 and err bit indices.
REQ-029 Round-robin selection SHALL be a sub-module rr_picker (inputs pending and rr_ptr; outputs grant index and any_pending).

Verification
REQ-030 Single read: req_valid[0] with addr 0x2F3 at t -> mem_req_valid at t+2 with addr 0x2F3; mem_resp data 0x7E at r -> resp_valid=01 and resp_data 0x7E at r+1.
REQ-031 Contention: both requesters pulse in the same cycle with rr_ptr=0 -> requester 0 is served first, requester 1 is issued at r+2, and rr_ptr ends at 0.
REQ-032 Overrun: a second req_valid[1] while the first is pending -> the pulse is dropped, err=001, and only one response reaches requester 1.
REQ-033 Timeout: with TIMEOUT_CYCLES=16 and no response -> resp_valid pulses 16 cycles after WAIT entry, resp_data=0, err=100.
REQ-034 Spurious response: mem_resp_valid while idle -> no resp_valid pulse and err=010.
REQ-035 Reset in WAIT followed by a late response -> outputs are 0 and err=010.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the DDR request arbiter: bus widths, error-flag bit
// positions, FSM encoding and the round-robin index helper.
package mem_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ERR_W  = 3;

  // Bit positions within the sticky err vector {timeout, spurious_resp, overrun}
  localparam int unsigned ERR_OVERRUN  = 0;
  localparam int unsigned ERR_SPURIOUS = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } arb_state_e;

  // Requester index visited at position 'offset' of a round-robin scan from 'ptr'
  function automatic int unsigned rr_index(input int unsigned ptr, input int unsigned offset,
                                           input int unsigned n);
    return (ptr + offset) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: picks the first pending requester at or after the
// pointer, wrapping around. Purely combinational.
module rr_picker
  import mem_if_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                               i_pending,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] i_rr_ptr,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant,
  output logic                                             o_any_pending
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Scan from the far end back toward the pointer so the closest hit wins last
  always_comb begin
    o_grant       = '0;
    o_any_pending = |i_pending;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_pending[IDX_W'(rr_index(32'(i_rr_ptr), k, NUM_REQ))]) begin
        o_grant = IDX_W'(rr_index(32'(i_rr_ptr), k, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one DDR request/response channel between NUM_REQ requesters.
// Requests are latched per requester, granted round-robin, and exactly one
// request is outstanding at a time; a WAIT timeout forces completion.
module mem_arbiter
  import mem_if_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_write,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [DATA_W-1:0]           mem_resp_data,
  output logic [ERR_W-1:0]            err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e          r_state, w_state_d;

  logic [NUM_REQ-1:0]  r_pending, w_pending_d;
  logic [NUM_REQ-1:0]  w_accept;
  logic                w_overrun;
  logic [ADDR_W-1:0]   r_addr  [NUM_REQ];
  logic [DATA_W-1:0]   r_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]  r_write;

  logic [IDX_W-1:0]    r_rr_ptr, w_rr_next;
  logic [IDX_W-1:0]    r_grant, w_grant;
  logic                w_any_pending;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_issue, w_complete, w_timeout, w_spurious;

  logic                r_mem_req_valid;
  logic                r_mem_req_write;
  logic [ADDR_W-1:0]   r_mem_req_addr;
  logic [DATA_W-1:0]   r_mem_req_wdata;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [ERR_W-1:0]    r_err;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_pending     (r_pending),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant       (w_grant),
    .o_any_pending (w_any_pending)
  );

  // FSM next state and the issue/complete/timeout/spurious strobes
  always_comb begin
    w_state_d  = r_state;
    w_issue    = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    w_spurious = 1'b0;
    case (r_state)
      StIdle: begin
        w_spurious = mem_resp_valid;
        if (w_any_pending) begin
          w_issue   = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          w_complete = 1'b1;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Registered response lands exactly TIMEOUT_CYCLES after WAIT entry
          w_complete = 1'b1;
          w_timeout  = 1'b1;
        end
        if (w_complete) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Pending next state: a new pulse is taken unless its slot is still busy
  always_comb begin
    w_pending_d = r_pending;
    w_accept    = '0;
    w_overrun   = 1'b0;
    if (w_complete) begin
      w_pending_d[r_grant] = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (!r_pending[i] || (w_complete && (r_grant == IDX_W'(i)))) begin
          w_pending_d[i] = 1'b1;
          w_accept[i]    = 1'b1;
        end else begin
          w_overrun = 1'b1;
        end
      end
    end
  end

  // Per-requester capture of pending flag and request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_write   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          r_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
          r_write[i] <= req_write[i];
        end
      end
    end
  end

  // Registered DDR request; fields hold between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_grant         <= '0;
    end else begin
      r_mem_req_valid <= w_issue;
      if (w_issue) begin
        r_mem_req_write <= r_write[w_grant];
        r_mem_req_addr  <= r_addr[w_grant];
        r_mem_req_wdata <= r_wdata[w_grant];
        r_grant         <= w_grant;
      end
    end
  end

  // WAIT cycle counter, cleared on the issue that enters WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if ((r_state == StWait) && !w_complete) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_rr_next = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Completion pulse to the granted requester and round-robin advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      if (w_complete) begin
        r_resp_valid[r_grant] <= 1'b1;
        r_resp_data           <= w_timeout ? '0 : mem_resp_data;
        r_rr_ptr              <= w_rr_next;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      if (w_overrun)  r_err[ERR_OVERRUN]  <= 1'b1;
      if (w_spurious) r_err[ERR_SPURIOUS] <= 1'b1;
      if (w_timeout)  r_err[ERR_TIMEOUT]  <= 1'b1;
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_write = r_mem_req_write;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_wdata = r_mem_req_wdata;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign err           = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses are queued when the DDR
// response is driven and popped when resp_valid is sampled.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   resp_valid;
  logic [7:0]        resp_data;
  logic              mem_req_valid;
  logic              mem_req_write;
  logic [31:0]       mem_req_addr;
  logic [7:0]        mem_req_wdata;
  logic              mem_resp_valid;
  logic [7:0]        mem_resp_data;
  logic [2:0]        err;

  typedef struct {
    int unsigned req;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int i, input logic wr, input logic [31:0] a, input logic [7:0] wd);
    req_valid[i]        = 1'b1;
    req_write[i]        = wr;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic drive_resp(input logic [7:0] d, input int unsigned to_req);
    exp_t e;
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    e.req  = to_req;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(resp_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1 << e.req);
      chk({tag, "_data"}, 32'(resp_data), 32'(e.data));
    end
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] a, input logic wr,
                           input logic [7:0] wd);
    chk({tag, "_mreq_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_mreq_addr"}, mem_req_addr, a);
    chk({tag, "_mreq_write"}, 32'(mem_req_write), 32'(wr));
    if (wr) chk({tag, "_mreq_wdata"}, 32'(mem_req_wdata), 32'(wd));
  endtask

  // Asynchronous assert mid-cycle; outputs must clear without a clock edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_mreq_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_rst_mreq_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_rst_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rst_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_rst_err"}, 32'(err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    bit got;
    rst_n          = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #2;
    do_reset("init");

    // Single read from requester 0
    drive_req(0, 1'b0, 32'h2F3, 8'h00);
    tick();
    clear_inputs();
    chk("rd_t1_mreq_valid", 32'(mem_req_valid), 32'd0);
    tick();
    chk_issue("rd", 32'h2F3, 1'b0, 8'h00);
    tick();
    chk("rd_one_cycle", 32'(mem_req_valid), 32'd0);
    chk("rd_addr_hold", mem_req_addr, 32'h2F3);
    drive_resp(8'h7E, 0);
    tick();
    clear_inputs();
    check_resp("rd");
    tick();
    chk("rd_resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("rd_err", 32'(err), 32'd0);

    // Write from requester 1, re-requesting in the cycle its response arrives
    drive_req(1, 1'b1, 32'h1000_0004, 8'hA5);
    tick();
    clear_inputs();
    tick();
    chk_issue("wr", 32'h1000_0004, 1'b1, 8'hA5);
    tick();
    drive_resp(8'h00, 1);
    drive_req(1, 1'b0, 32'h404, 8'h00);
    tick();
    clear_inputs();
    check_resp("wr");
    chk("same_cycle_no_overrun", 32'(err), 32'd0);
    tick();
    chk_issue("reissue", 32'h404, 1'b0, 8'h00);
    tick();
    drive_resp(8'h44, 1);
    tick();
    clear_inputs();
    check_resp("reissue");

    // Contention with rr_ptr at 0: requester 0 first, requester 1 at r+2
    drive_req(0, 1'b0, 32'h100, 8'h00);
    drive_req(1, 1'b0, 32'h200, 8'h00);
    tick();
    clear_inputs();
    tick();
    chk_issue("cont0", 32'h100, 1'b0, 8'h00);
    tick();
    drive_resp(8'h11, 0);
    tick();
    clear_inputs();
    check_resp("cont0");
    chk("cont_r1_idle", 32'(mem_req_valid), 32'd0);
    tick();
    chk_issue("cont1", 32'h200, 1'b0, 8'h00);
    tick();
    drive_resp(8'h22, 1);
    tick();
    clear_inputs();
    check_resp("cont1");
    chk("cont_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);

    // Overrun: second pulse from requester 1 while still pending
    drive_req(1, 1'b0, 32'h300, 8'h00);
    tick();
    drive_req(1, 1'b0, 32'h3FF, 8'h00);
    tick();
    clear_inputs();
    chk_issue("ovr", 32'h300, 1'b0, 8'h00);
    chk("ovr_err", 32'(err), 32'b001);
    tick();
    drive_resp(8'h33, 1);
    tick();
    clear_inputs();
    check_resp("ovr");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ovr_no_extra_resp", 32'(resp_valid), 32'd0);
      chk("ovr_no_extra_mreq", 32'(mem_req_valid), 32'd0);
    end
    chk("ovr_err_sticky", 32'(err), 32'b001);

    // Timeout after 16 cycles in WAIT with no response
    do_reset("pre_to");
    mem_resp_data = 8'hEE;
    drive_req(0, 1'b0, 32'h500, 8'h00);
    tick();
    clear_inputs();
    tick();
    chk_issue("to", 32'h500, 1'b0, 8'h00);
    sb.push_back('{req: 0, data: 8'h00});
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      tick();
      k++;
      if (resp_valid != '0) got = 1'b1;
    end
    chk("to_latency", 32'(k), 32'd16);
    check_resp("to");
    chk("to_err", 32'(err), 32'b100);

    // Spurious response while idle
    do_reset("pre_sp");
    drive_resp(8'h99, 0);
    void'(sb.pop_back());
    tick();
    clear_inputs();
    chk("sp_no_resp", 32'(resp_valid), 32'd0);
    chk("sp_err", 32'(err), 32'b010);
    tick();
    chk("sp_no_resp_later", 32'(resp_valid), 32'd0);

    // Reset while waiting, then a late response
    do_reset("pre_rw");
    drive_req(0, 1'b0, 32'h600, 8'h00);
    tick();
    clear_inputs();
    tick();
    chk_issue("rw", 32'h600, 1'b0, 8'h00);
    tick();
    do_reset("rw");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 8'h55;
    tick();
    clear_inputs();
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_data", 32'(resp_data), 32'd0);
    chk("rw_mreq_valid", 32'(mem_req_valid), 32'd0);
    chk("rw_err", 32'(err), 32'b010);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
